wasm_operand_stack: RTL and testbench
=====================================

// Module: wasm_operand_stack
// PURPOSE
//   Parametrised operand stack for the WASM execution datapath. Each accepted
//   op pops 0..POP_MAX entries and pushes 0..PUSH_MAX entries atomically.
//   Adds exact occupancy tracking, sticky overflow/underflow detection that
//   blocks the op and stalls the issuer, a flush, and a random-depth peek port.
// PARAMETERS
//   WIDTH     32  bits per stack entry
//   DEPTH     16  number of entries (>= POP_MAX, >= PUSH_MAX, >= 2)
//   POP_MAX   3   max entries popped per op; sets pop_window size
//   PUSH_MAX  2   max entries pushed per op
//   CW = $clog2(DEPTH+1), PW = $clog2(POP_MAX+1), UW = $clog2(PUSH_MAX+1),
//   IW = $clog2(DEPTH) (derived localparams)
// PORTS
//   clk         in   1               clock, single domain
//   rst_n       in   1               asynchronous active-low reset
//   op_valid    in   1               op request
//   op_ready    out  1               op can be accepted
//   pop_num     in   PW              entries to pop (0..POP_MAX)
//   push_num    in   UW              entries to push (0..PUSH_MAX)
//   push_data   in   PUSH_MAX*WIDTH  slot k = bits [k*WIDTH +: WIDTH]
//   flush       in   1               empty the stack
//   err_clr     in   1               clear sticky error flags
//   pop_window  out  POP_MAX*WIDTH   slot i = entry at depth i (0 = top)
//   window_vld  out  POP_MAX         bit i = (i < count)
//   pick_idx    in   IW              peek depth (0 = top)
//   pick_data   out  WIDTH           entry at depth pick_idx, 0 if invalid
//   pick_vld    out  1               pick_idx < count
//   count       out  CW              number of valid entries, 0..DEPTH
//   full        out  1               count == DEPTH
//   empty       out  1               count == 0
//   overflow    out  1               sticky: op would exceed DEPTH
//   underflow   out  1               sticky: op popped more than count
// BEHAVIOUR
//   Reset: count=0, all entries=0, overflow=underflow=0. Therefore empty=1,
//     full=0, op_ready=1, pop_window=0, window_vld=0, pick_data=0, pick_vld=0.
//   op_ready = !(overflow | underflow). It is combinational from flags only,
//     never from op_valid.
//   Accept = op_valid & op_ready at posedge clk. Accepted ops take effect at
//     that edge; all outputs reflect the new state in the following cycle.
//     The next op may issue back-to-back, one op per cycle.
//   Legality is checked on the pre-op count C:
//     underflow if pop_num > C
//     overflow  if C - pop_num + push_num > DEPTH
//     Illegal op: stack contents and count are unchanged; the flag is set.
//     Underflow has priority, so only one flag is set per op.
//   Legal op: remove the top pop_num entries, then push slots 0..push_num-1
//     in order. Slot push_num-1 ends at depth 0, slot 0 at depth push_num-1.
//     New count = C - pop_num + push_num.
//   pop_num > POP_MAX or push_num > PUSH_MAX: treat as an illegal op and set
//     underflow. No state change.
//   Push slots at index >= push_num are ignored, whatever their value.
//   pop_window, window_vld, pick_*, count, full and empty are combinational
//     from registered state only. Invalid slots read 0; stale data is never
//     exposed.
//   flush (no handshake): the next edge sets count=0 and data reads as 0.
//     flush wins over a same-cycle accepted op, which is discarded with no
//     flag update. Flags are unaffected by flush.
//   err_clr: the next edge clears both flags. If the same-cycle op is
//     illegal, its new flag wins (set beats clear). op_ready is low that cycle
//     only if a flag is already set, so no op is accepted while errored.
//   Storage is unchanged in any cycle without an accept or flush.
//   Async reset asserted mid-stream clears everything immediately. There is
//     no partial op.
// TESTING
//   1. Reset, then push 0xA,0xB (push_num=2) -> count=2, window={0xB,0xA,0},
//      window_vld=3'b011.
//   2. From 1, pop_num=2 with push_num=1, data 0x15 -> count=1, top=0x15,
//      empty=0 (models a binary i32.add).
//   3. Fill to DEPTH=16, then push 1 -> overflow=1, op_ready=0, count=16,
//      contents intact. Then err_clr -> op_ready=1.
//   4. count=1, pop_num=2 -> underflow=1 and count stays 1. Same cycle as an
//      err_clr with an illegal op -> the flag stays 1.
//   5. count=5, pick_idx=4 -> deepest entry with pick_vld=1. pick_idx=5 ->
//      pick_data=0, pick_vld=0.
//   6. flush together with an accepted push, then async reset mid-burst ->
//      count=0 and empty=1 in both cases; all outputs return to reset values.

Source files
------------

// File: rtl/wasm_operand_stack.sv
// Operand stack for the WASM datapath: atomic pop-then-push per op, with sticky
// overflow/underflow flags that stall the issuer, flush, and a random-depth peek.
module wasm_operand_stack #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned POP_MAX  = 3,
  parameter int unsigned PUSH_MAX = 2,
  localparam int unsigned CW = $clog2(DEPTH + 1),
  localparam int unsigned PW = $clog2(POP_MAX + 1),
  localparam int unsigned UW = $clog2(PUSH_MAX + 1),
  localparam int unsigned IW = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      op_valid,
  output logic                      op_ready,
  input  logic [PW-1:0]             pop_num,
  input  logic [UW-1:0]             push_num,
  input  logic [PUSH_MAX*WIDTH-1:0] push_data,
  input  logic                      flush,
  input  logic                      err_clr,
  output logic [POP_MAX*WIDTH-1:0]  pop_window,
  output logic [POP_MAX-1:0]        window_vld,
  input  logic [IW-1:0]             pick_idx,
  output logic [WIDTH-1:0]          pick_data,
  output logic                      pick_vld,
  output logic [CW-1:0]             count,
  output logic                      full,
  output logic                      empty,
  output logic                      overflow,
  output logic                      underflow
);

  // Entries are stored bottom-up: address 0 is the oldest, count-1 is the top.
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic [CW:0] c_ext, pop_ext, push_ext, base, new_count;
  logic [31:0] pop_w, push_w;
  logic        bad_num, is_under, is_over, accept, commit;

  assign op_ready = ~(overflow_q | underflow_q);
  assign accept   = op_valid & op_ready;

  always_comb begin
    c_ext     = {1'b0, count_q};
    pop_ext   = (CW + 1)'(pop_num);
    push_ext  = (CW + 1)'(push_num);
    pop_w     = 32'(pop_num);
    push_w    = 32'(push_num);
    bad_num   = (pop_w > POP_MAX) | (push_w > PUSH_MAX);
    base      = c_ext - pop_ext;
    new_count = base + push_ext;
    is_under  = bad_num | (pop_ext > c_ext);
    is_over   = ~is_under & (new_count > (CW + 1)'(DEPTH));
    commit    = accept & ~flush & ~is_under & ~is_over;
  end

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (commit) begin
      count_d = new_count[CW-1:0];
    end
  end

  // Set beats clear; an op discarded by flush leaves the flags alone.
  always_comb begin
    overflow_d  = overflow_q & ~err_clr;
    underflow_d = underflow_q & ~err_clr;
    if (accept && !flush) begin
      if (is_under) underflow_d = 1'b1;
      if (is_over)  overflow_d  = 1'b1;
    end
  end

  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      mem_d[j] = mem_q[j];
      if (commit) begin
        for (int k = 0; k < PUSH_MAX; k++) begin
          if ((UW'(k) < push_num) && ((base + (CW + 1)'(k)) == (CW + 1)'(j))) begin
            mem_d[j] = push_data[k*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      for (int j = 0; j < DEPTH; j++) mem_q[j] <= '0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      for (int j = 0; j < DEPTH; j++) mem_q[j] <= mem_d[j];
    end
  end

  // Reads are masked by count so flushed or popped data never leaks out.
  always_comb begin
    pop_window = '0;
    window_vld = '0;
    for (int i = 0; i < POP_MAX; i++) begin
      if (CW'(i) < count_q) begin
        window_vld[i]                = 1'b1;
        pop_window[i*WIDTH +: WIDTH] = mem_q[IW'(count_q - CW'(i) - CW'(1))];
      end
    end
  end

  always_comb begin
    pick_vld  = CW'(pick_idx) < count_q;
    pick_data = '0;
    if (pick_vld) begin
      pick_data = mem_q[IW'(count_q - CW'(pick_idx) - CW'(1))];
    end
  end

  assign count     = count_q;
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_wasm_operand_stack.sv
// Directed self-checking bench for wasm_operand_stack with default parameters.
module tb_wasm_operand_stack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [1:0]  pop_num = '0;
  logic [1:0]  push_num = '0;
  logic [63:0] push_data = '0;
  logic        flush = 1'b0;
  logic        err_clr = 1'b0;
  logic [95:0] pop_window;
  logic [2:0]  window_vld;
  logic [3:0]  pick_idx = '0;
  logic [31:0] pick_data;
  logic        pick_vld;
  logic [4:0]  count;
  logic        full, empty, overflow, underflow;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wasm_operand_stack dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .pop_num    (pop_num),
    .push_num   (push_num),
    .push_data  (push_data),
    .flush      (flush),
    .err_clr    (err_clr),
    .pop_window (pop_window),
    .window_vld (window_vld),
    .pick_idx   (pick_idx),
    .pick_data  (pick_data),
    .pick_vld   (pick_vld),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  // One op presented for exactly one edge; outputs are settled on return.
  task automatic do_op(input logic [1:0] p, input logic [1:0] u,
                       input logic [31:0] d0, input logic [31:0] d1);
    op_valid  = 1'b1;
    pop_num   = p;
    push_num  = u;
    push_data = {d1, d0};
    @(posedge clk);
    #1;
    op_valid  = 1'b0;
    pop_num   = '0;
    push_num  = '0;
    push_data = '0;
  endtask

  task automatic test_reset;
    if (count !== 5'd0) begin $display("FAIL reset_count got %0d want 0", count); n_err++; end
    n_cmp++;
    if ({empty, full, op_ready} !== 3'b101) begin
      $display("FAIL reset_flags e/f/r got %b want 101", {empty, full, op_ready}); n_err++;
    end
    n_cmp++;
    if ({pop_window, window_vld} !== '0) begin
      $display("FAIL reset_window got %h/%b want 0", pop_window, window_vld); n_err++;
    end
    n_cmp++;
    if ({pick_data, pick_vld, overflow, underflow} !== '0) begin
      $display("FAIL reset_pick_err got %h %b %b %b want 0", pick_data, pick_vld, overflow,
               underflow); n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_push_pop;
    do_op(2'd0, 2'd2, 32'hA, 32'hB);
    if (count !== 5'd2) begin $display("FAIL push2_count got %0d want 2", count); n_err++; end
    n_cmp++;
    if (pop_window !== {32'h0, 32'hA, 32'hB} || window_vld !== 3'b011) begin
      $display("FAIL push2_window got %h/%b want 0..0a..0b/011", pop_window, window_vld); n_err++;
    end
    n_cmp++;
    // Binary op: pop 2, push 1; slot 1 holds junk that must be ignored.
    do_op(2'd2, 2'd1, 32'h15, 32'hDEAD_BEEF);
    if (count !== 5'd1 || empty !== 1'b0) begin
      $display("FAIL add_count got %0d/%b want 1/0", count, empty); n_err++;
    end
    n_cmp++;
    if (pop_window !== {64'h0, 32'h15} || window_vld !== 3'b001) begin
      $display("FAIL add_window got %h/%b want 15/001", pop_window, window_vld); n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_overflow;
    for (int k = 0; k < 7; k++) do_op(2'd0, 2'd2, 32'h100 + 2 * k, 32'h101 + 2 * k);
    do_op(2'd0, 2'd1, 32'h10E, 32'h0);
    if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b0) begin
      $display("FAIL fill_count got %0d/%b/%b want 16/1/0", count, full, overflow); n_err++;
    end
    n_cmp++;
    do_op(2'd0, 2'd1, 32'h999, 32'h0);
    if ({overflow, underflow, op_ready} !== 3'b100 || count !== 5'd16) begin
      $display("FAIL ovf_flags got o/u/r=%b cnt=%0d want 100/16",
               {overflow, underflow, op_ready}, count); n_err++;
    end
    n_cmp++;
    if (pop_window !== {32'h10C, 32'h10D, 32'h10E}) begin
      $display("FAIL ovf_contents got %h want 10c/10d/10e", pop_window); n_err++;
    end
    n_cmp++;
    pick_idx = 4'd15;
    #1;
    if (pick_data !== 32'h15 || pick_vld !== 1'b1) begin
      $display("FAIL ovf_deepest got %h/%b want 15/1", pick_data, pick_vld); n_err++;
    end
    n_cmp++;
    // Issuer is stalled while errored: op is not accepted.
    do_op(2'd1, 2'd0, 32'h0, 32'h0);
    if (count !== 5'd16) begin $display("FAIL stall_count got %0d want 16", count); n_err++; end
    n_cmp++;
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    if (op_ready !== 1'b1 || overflow !== 1'b0) begin
      $display("FAIL errclr_ready got %b/%b want 1/0", op_ready, overflow); n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_underflow;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    do_op(2'd0, 2'd1, 32'h7, 32'h0);
    do_op(2'd2, 2'd0, 32'h0, 32'h0);
    if ({underflow, overflow, op_ready} !== 3'b100 || count !== 5'd1) begin
      $display("FAIL unf_flags got u/o/r=%b cnt=%0d want 100/1",
               {underflow, overflow, op_ready}, count); n_err++;
    end
    n_cmp++;
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    if (underflow !== 1'b0) begin $display("FAIL unf_clr got %b want 0", underflow); n_err++; end
    n_cmp++;
    // err_clr still high with a fresh illegal op: set beats clear.
    do_op(2'd2, 2'd0, 32'h0, 32'h0);
    err_clr = 1'b0;
    if (underflow !== 1'b1 || count !== 5'd1) begin
      $display("FAIL unf_set_beats_clr got %b/%0d want 1/1", underflow, count); n_err++;
    end
    n_cmp++;
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    // push_num beyond PUSH_MAX is an illegal op flagged as underflow.
    do_op(2'd0, 2'd3, 32'h55, 32'h66);
    if (underflow !== 1'b1 || count !== 5'd1 || pop_window[31:0] !== 32'h7) begin
      $display("FAIL bad_push_num got %b/%0d/%h want 1/1/7", underflow, count,
               pop_window[31:0]); n_err++;
    end
    n_cmp++;
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
  endtask

  task automatic test_pick;
    do_op(2'd0, 2'd2, 32'h1, 32'h2);
    do_op(2'd0, 2'd2, 32'h3, 32'h4);
    pick_idx = 4'd4;
    #1;
    if (pick_data !== 32'h7 || pick_vld !== 1'b1 || count !== 5'd5) begin
      $display("FAIL pick4 got %h/%b cnt=%0d want 7/1/5", pick_data, pick_vld, count); n_err++;
    end
    n_cmp++;
    pick_idx = 4'd0;
    #1;
    if (pick_data !== 32'h4 || pick_vld !== 1'b1) begin
      $display("FAIL pick0 got %h/%b want 4/1", pick_data, pick_vld); n_err++;
    end
    n_cmp++;
    pick_idx = 4'd5;
    #1;
    if (pick_data !== 32'h0 || pick_vld !== 1'b0) begin
      $display("FAIL pick5 got %h/%b want 0/0", pick_data, pick_vld); n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_flush_reset;
    flush = 1'b1;
    do_op(2'd0, 2'd2, 32'hAA, 32'hBB);
    flush = 1'b0;
    if (count !== 5'd0 || empty !== 1'b1 || pop_window !== '0 || underflow !== 1'b0) begin
      $display("FAIL flush_op got cnt=%0d e=%b win=%h u=%b want 0/1/0/0", count, empty,
               pop_window, underflow); n_err++;
    end
    n_cmp++;
    // Back-to-back pushes, one per cycle.
    op_valid  = 1'b1;
    push_num  = 2'd1;
    for (int k = 1; k <= 3; k++) begin
      push_data = {32'h0, 32'(k)};
      @(posedge clk);
      #1;
    end
    if (count !== 5'd3 || pop_window !== {32'h1, 32'h2, 32'h3} || window_vld !== 3'b111) begin
      $display("FAIL b2b got cnt=%0d win=%h vld=%b want 3/1,2,3/111", count, pop_window,
               window_vld); n_err++;
    end
    n_cmp++;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    if (count !== 5'd0 || empty !== 1'b1 || pop_window !== '0 || op_ready !== 1'b1
        || pick_vld !== 1'b0) begin
      $display("FAIL async_reset got cnt=%0d e=%b win=%h r=%b pv=%b", count, empty, pop_window,
               op_ready, pick_vld); n_err++;
    end
    n_cmp++;
    op_valid = 1'b0;
    push_num = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    if (count !== 5'd0 || {overflow, underflow} !== 2'b00) begin
      $display("FAIL post_reset got cnt=%0d o/u=%b want 0/00", count, {overflow, underflow});
      n_err++;
    end
    n_cmp++;
  endtask

  initial begin
    #12;
    test_reset;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_push_pop;
    test_overflow;
    test_underflow;
    test_pick;
    test_flush_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
